dmem_arbiter: RTL and testbench

Two-port arbiter sharing the single-port data memory between the processor's load/store path and a host port used for program loading and debug inspection. Sits between the core's data-memory address/write-data/read-data nets and the data memory instance. CPU accesses complete in the same cycle or stall the core; host accesses use a request/acknowledge handshake. Fairness is round-robin, with an optional host lock for atomic multi-word host sequences.

---
 rtl/dmem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU load/store path and a host port.
// Optional host lock for atomic host sequences is enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic          host_lock,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_ack,
  output logic          lock_abort,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {H_IDLE, H_ACK} hstate_e;

  hstate_e         state_q, state_d;
  logic            prio_q, prio_d;
  logic            host_ack_q, host_ack_d;
  logic [DW-1:0]   host_rdata_q, host_rdata_d;

  logic            host_elig, cpu_elig;
  logic            host_gnt, cpu_gnt;
  logic            lock_active;
  logic            lock_expire;

`ifdef DMEM_ARB_LOCK_EN
  localparam int unsigned CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  logic          lock_q, lock_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          lock_abort_q, lock_abort_d;

  assign lock_active = lock_q;
  assign lock_expire = lock_q & (lock_cnt_q == CW'(LOCK_MAX - 1));
  assign lock_abort  = lock_abort_q;

  // Lock acquire / hold / release; the cycle that hits the limit is still a locked cycle
  always_comb begin
    lock_d       = lock_q;
    lock_cnt_d   = lock_cnt_q;
    lock_abort_d = 1'b0;
    if (lock_q) begin
      if (lock_expire) begin
        lock_d       = 1'b0;
        lock_cnt_d   = '0;
        lock_abort_d = 1'b1;
      end else begin
        lock_cnt_d = lock_cnt_q + CW'(1);
        if (host_gnt && !host_lock) begin
          lock_d     = 1'b0;
          lock_cnt_d = '0;
        end
      end
    end else if (host_gnt && host_lock) begin
      lock_d     = 1'b1;
      lock_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q       <= 1'b0;
      lock_cnt_q   <= '0;
      lock_abort_q <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_cnt_q   <= lock_cnt_d;
      lock_abort_q <= lock_abort_d;
    end
  end
`else
  logic unused_lock;

  assign lock_active = 1'b0;
  assign lock_expire = 1'b0;
  assign lock_abort  = 1'b0;
  assign unused_lock = host_lock | (LOCK_MAX == 0);
`endif

  // Eligibility and grant; a held lock gives the host absolute priority
  always_comb begin
    host_elig = host_req & (state_q == H_IDLE) & ~rst;
    cpu_elig  = cpu_req & ~rst & ~lock_active;
    host_gnt  = host_elig & (~cpu_elig | prio_q | lock_active);
    cpu_gnt   = cpu_elig & ~host_gnt;
  end

  assign cpu_stall  = cpu_req & ~rst & ~cpu_gnt;
  assign cpu_rdata  = mem_rdata;
  assign host_rdata = host_rdata_q;
  assign host_ack   = host_ack_q & ~rst;

  // Memory port mux; idle cycles leave address/data following the CPU
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (host_gnt) begin
      mem_we    = host_we;
      mem_re    = ~host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (cpu_gnt) begin
      mem_we = cpu_we;
      mem_re = ~cpu_we;
    end
  end

  // Host handshake FSM and round-robin priority
  always_comb begin
    state_d      = H_IDLE;
    prio_d       = prio_q;
    host_ack_d   = host_gnt;
    host_rdata_d = host_rdata_q;
    case (state_q)
      H_IDLE:  state_d = host_gnt ? H_ACK : H_IDLE;
      H_ACK:   state_d = H_IDLE;
      default: state_d = H_IDLE;
    endcase
    if (cpu_gnt) begin
      prio_d = 1'b1;
    end else if (host_gnt) begin
      prio_d = 1'b0;
    end
    if (lock_expire) begin
      prio_d = 1'b0;
    end
    if (host_gnt && !host_we) begin
      host_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= H_IDLE;
      prio_q       <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural data memory.
// Lock scenario is compiled only when DMEM_ARB_LOCK_EN is defined (LOCK_MAX=4).
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        host_req, host_we, host_lock;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic        host_ack, lock_abort;
  logic        mem_we, mem_re;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];

  int tests;
  int fails;

  dmem_arbiter #(.AW(32), .DW(32), .LOCK_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_lock  (host_lock),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_ack   (host_ack),
    .lock_abort (lock_abort),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word-addressed memory model, preloaded during reset
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h0000_1234;
      mem[8] <= 32'h0000_A5A5;
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  always_comb mem_rdata = mem[mem_addr[9:2]];

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    host_req = 1'b0; host_we = 1'b0; host_lock = 1'b0; host_addr = 32'h0; host_wdata = 32'h0;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    next_cycle();
    rst = 1'b1;
    cpu_req = 1'b1; cpu_addr = 32'h10; host_req = 1'b1; host_we = 1'b1; host_addr = 32'h20;
    #1;
    tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    tests++; if (mem_re !== 1'b0) begin fails++; $display("FAIL reset_mem_re got=%b exp=0", mem_re); end
    tests++; if (host_ack !== 1'b0) begin fails++; $display("FAIL reset_host_ack got=%b exp=0", host_ack); end
    tests++; if (host_rdata !== 32'h0) begin fails++; $display("FAIL reset_host_rdata got=%h exp=0", host_rdata); end
    tests++; if (lock_abort !== 1'b0) begin fails++; $display("FAIL reset_lock_abort got=%b exp=0", lock_abort); end
    next_cycle();
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_cpu_load();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    #1;
    tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL cpu_load_stall got=%b exp=0", cpu_stall); end
    tests++; if (cpu_rdata !== 32'h1234) begin fails++; $display("FAIL cpu_load_rdata got=%h exp=00001234", cpu_rdata); end
    tests++; if (mem_re !== 1'b1) begin fails++; $display("FAIL cpu_load_mem_re got=%b exp=1", mem_re); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL cpu_load_mem_we got=%b exp=0", mem_we); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_contention();
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h10; host_req = 1'b1; host_we = 1'b0; host_addr = 32'h20;
    #1;
    tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL cont_c0_stall got=%b exp=0", cpu_stall); end
    tests++; if (mem_addr !== 32'h10) begin fails++; $display("FAIL cont_c0_addr got=%h exp=00000010", mem_addr); end
    next_cycle();
    #1;
    tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL cont_c1_stall got=%b exp=1", cpu_stall); end
    tests++; if (mem_addr !== 32'h20) begin fails++; $display("FAIL cont_c1_addr got=%h exp=00000020", mem_addr); end
    tests++; if (host_ack !== 1'b0) begin fails++; $display("FAIL cont_c1_ack got=%b exp=0", host_ack); end
    next_cycle();
    host_req = 1'b0;
    #1;
    tests++; if (host_ack !== 1'b1) begin fails++; $display("FAIL cont_c2_ack got=%b exp=1", host_ack); end
    tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL cont_c2_stall got=%b exp=0", cpu_stall); end
    tests++; if (host_rdata !== 32'hA5A5) begin fails++; $display("FAIL cont_c2_rdata got=%h exp=0000a5a5", host_rdata); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_host_write_read();
    do_reset();
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h40; host_wdata = 32'hDEAD_BEEF;
    #1;
    tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL hwr_mem_we got=%b exp=1", mem_we); end
    next_cycle();
    host_req = 1'b0;
    #1;
    tests++; if (host_ack !== 1'b1) begin fails++; $display("FAIL hwr_wr_ack got=%b exp=1", host_ack); end
    tests++; if (host_rdata !== 32'h0) begin fails++; $display("FAIL hwr_wr_rdata got=%h exp=0", host_rdata); end
    tests++; if (mem[16] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL hwr_mem_commit got=%h exp=deadbeef", mem[16]); end
    next_cycle();
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h40;
    #1;
    tests++; if (host_ack !== 1'b0) begin fails++; $display("FAIL hwr_gap_ack got=%b exp=0", host_ack); end
    next_cycle();
    host_req = 1'b0;
    #1;
    tests++; if (host_ack !== 1'b1) begin fails++; $display("FAIL hwr_rd_ack got=%b exp=1", host_ack); end
    tests++; if (host_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL hwr_rd_rdata got=%h exp=deadbeef", host_rdata); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic prev_stall;
    logic exp_host;
    do_reset();
    prev_stall = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h10; host_req = 1'b1; host_we = 1'b0; host_addr = 32'h20;
    for (int i = 0; i < 20; i++) begin
      #1;
      exp_host = (i % 2) == 1;
      tests++; if (cpu_stall !== exp_host) begin fails++; $display("FAIL b2b_stall cyc=%0d got=%b exp=%b", i, cpu_stall, exp_host); end
      tests++; if (mem_addr !== (exp_host ? 32'h20 : 32'h10)) begin fails++; $display("FAIL b2b_owner cyc=%0d got=%h exp_host=%b", i, mem_addr, exp_host); end
      tests++; if (prev_stall && cpu_stall) begin fails++; $display("FAIL b2b_double_stall cyc=%0d got=1 exp=0", i); end
      prev_stall = cpu_stall;
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_simul_write();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h1111;
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h80; host_wdata = 32'h2222;
    #1;
    tests++; if (mem_wdata !== 32'h1111) begin fails++; $display("FAIL sw_c0_wdata got=%h exp=00001111", mem_wdata); end
    tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL sw_c0_stall got=%b exp=0", cpu_stall); end
    next_cycle();
    cpu_req = 1'b0;
    #1;
    tests++; if (mem[32] !== 32'h1111) begin fails++; $display("FAIL sw_cpu_commit got=%h exp=00001111", mem[32]); end
    tests++; if (mem_wdata !== 32'h2222) begin fails++; $display("FAIL sw_c1_wdata got=%h exp=00002222", mem_wdata); end
    next_cycle();
    host_req = 1'b0;
    #1;
    tests++; if (mem[32] !== 32'h2222) begin fails++; $display("FAIL sw_host_commit got=%h exp=00002222", mem[32]); end
    tests++; if (host_ack !== 1'b1) begin fails++; $display("FAIL sw_ack got=%b exp=1", host_ack); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h20;
    #1;
    tests++; if (mem_re !== 1'b1 || mem_addr !== 32'h20) begin fails++; $display("FAIL rm_grant got_re=%b got_addr=%h exp=1/00000020", mem_re, mem_addr); end
    next_cycle();
    rst = 1'b1; host_req = 1'b0; cpu_req = 1'b1; cpu_addr = 32'h10;
    #1;
    tests++; if (host_ack !== 1'b0) begin fails++; $display("FAIL rm_ack_in_rst got=%b exp=0", host_ack); end
    tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL rm_stall_in_rst got=%b exp=0", cpu_stall); end
    next_cycle();
    rst = 1'b0; host_req = 1'b1;
    #1;
    tests++; if (host_ack !== 1'b0) begin fails++; $display("FAIL rm_ack_after got=%b exp=0", host_ack); end
    tests++; if (host_rdata !== 32'h0) begin fails++; $display("FAIL rm_rdata_after got=%h exp=0", host_rdata); end
    tests++; if (cpu_stall !== 1'b0 || mem_addr !== 32'h10) begin fails++; $display("FAIL rm_prio got_stall=%b got_addr=%h exp=0/00000010", cpu_stall, mem_addr); end
    next_cycle();
    idle_inputs();
  endtask

`ifdef DMEM_ARB_LOCK_EN
  task automatic test_lock();
    logic exp_stall;
    logic exp_abort;
    do_reset();
    host_req = 1'b1; host_lock = 1'b1; host_we = 1'b0; host_addr = 32'h20;
    #1;
    tests++; if (mem_addr !== 32'h20) begin fails++; $display("FAIL lock_c0_addr got=%h exp=00000020", mem_addr); end
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 32'h10;
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) host_req = 1'b0;
      #1;
      exp_stall = (i <= 4);
      exp_abort = (i == 5);
      tests++; if (cpu_stall !== exp_stall) begin fails++; $display("FAIL lock_stall cyc=%0d got=%b exp=%b", i, cpu_stall, exp_stall); end
      tests++; if (lock_abort !== exp_abort) begin fails++; $display("FAIL lock_abort cyc=%0d got=%b exp=%b", i, lock_abort, exp_abort); end
      next_cycle();
    end
    idle_inputs();
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_cpu_load();
    test_contention();
    test_host_write_read();
    test_back_to_back();
    test_simul_write();
    test_reset_mid();
`ifdef DMEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
